switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 120 ++++++++++++
 tb/tb_switch_debouncer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchronizers and per-bit debounce FSMs for the board switches,
// with registered pulses for start edges and configuration changes.
module switch_debouncer #(
    parameter int DB_CYCLES = 50000,
    parameter int CW        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] red_raw,
    input  logic [1:0] green_raw,
    input  logic [1:0] blue_raw,
    input  logic [1:0] tran_raw,
    input  logic       gtype_raw,
    input  logic       start_raw,
    output logic [1:0] red_switches,
    output logic [1:0] green_switches,
    output logic [1:0] blue_switches,
    output logic [1:0] tran_switches,
    output logic       gtype_switch,
    output logic       switchStart,
    output logic       start_pulse,
    output logic       cfg_changed
);

    localparam int NB = 10;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {
        STABLE,
        COUNTING
    } db_state_t;

    logic [NB-1:0] raw_bits;
    logic [NB-1:0] sync_s1;
    logic [NB-1:0] sync_s2;
    logic [NB-1:0] deb_q;
    logic [NB-1:0] deb_d;
    db_state_t     state_q [NB];
    db_state_t     state_d [NB];
    logic [CW-1:0] cnt_q   [NB];
    logic [CW-1:0] cnt_d   [NB];

    // Bits 0..8 are configuration switches; bit 9 is the start switch.
    assign raw_bits = {start_raw, gtype_raw, tran_raw, blue_raw, green_raw, red_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
        end else begin
            sync_s1 <= raw_bits;
            sync_s2 <= sync_s1;
        end
    end

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == STABLE) begin
                if (sync_s2[i] != deb_q[i]) begin
                    if (DB_CYCLES == 1) begin
                        deb_d[i] = sync_s2[i];
                    end else begin
                        state_d[i] = COUNTING;
                        cnt_d[i]   = CW'(1);
                    end
                end
            end else begin
                // A single agreeing sample rejects the whole pending change.
                if (sync_s2[i] == deb_q[i]) begin
                    state_d[i] = STABLE;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i]   = sync_s2[i];
                    state_d[i] = STABLE;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Pulses are registered alongside the debounced value they announce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_changed <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            cfg_changed <= |(deb_d[8:0] ^ deb_q[8:0]);
            start_pulse <= deb_d[9] & ~deb_q[9];
        end
    end

    assign red_switches   = deb_q[1:0];
    assign green_switches = deb_q[3:2];
    assign blue_switches  = deb_q[5:4];
    assign tran_switches  = deb_q[7:6];
    assign gtype_switch   = deb_q[8];
    assign switchStart    = deb_q[9];

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized bench for switch_debouncer (DB_CYCLES = 4 and 1) against a
// sliding-window model of the synchronized switch streams.
module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] raw;

    logic [1:0] red4, green4, blue4, tran4;
    logic       gtype4, start4, spulse4, cfg4;
    logic [1:0] red1, green1, blue1, tran1;
    logic       gtype1, start1, spulse1, cfg1;

    wire [9:0] outVec4 = {start4, gtype4, tran4, blue4, green4, red4};
    wire [9:0] outVec1 = {start1, gtype1, tran1, blue1, green1, red1};

    int checks   = 0;
    int failures = 0;

    logic [9:0] rawHist  [$];
    logic [9:0] seenHist [$];
    logic [9:0] modelDeb4, modelDeb1;
    logic       expCfg4, expStart4, expCfg1, expStart1;

    switch_debouncer #(.DB_CYCLES(4), .CW(16)) dut4 (
        .clk(clk), .rst(rst),
        .red_raw(raw[1:0]), .green_raw(raw[3:2]), .blue_raw(raw[5:4]), .tran_raw(raw[7:6]),
        .gtype_raw(raw[8]), .start_raw(raw[9]),
        .red_switches(red4), .green_switches(green4), .blue_switches(blue4),
        .tran_switches(tran4), .gtype_switch(gtype4), .switchStart(start4),
        .start_pulse(spulse4), .cfg_changed(cfg4)
    );

    switch_debouncer #(.DB_CYCLES(1), .CW(4)) dut1 (
        .clk(clk), .rst(rst),
        .red_raw(raw[1:0]), .green_raw(raw[3:2]), .blue_raw(raw[5:4]), .tran_raw(raw[7:6]),
        .gtype_raw(raw[8]), .start_raw(raw[9]),
        .red_switches(red1), .green_switches(green1), .blue_switches(blue1),
        .tran_switches(tran1), .gtype_switch(gtype1), .switchStart(start1),
        .start_pulse(spulse1), .cfg_changed(cfg1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0h required %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // A bit flips once its last db synchronized samples all disagree with it.
    function automatic logic [9:0] modelStep(input int db, input logic [9:0] deb);
        logic [9:0] nxt;
        logic       allDiff;
        int         n;
        nxt = deb;
        n   = seenHist.size();
        for (int b = 0; b < 10; b++) begin
            if (n >= db) begin
                allDiff = 1'b1;
                for (int k = n - db; k < n; k++)
                    if (seenHist[k][b] == deb[b]) allDiff = 1'b0;
                if (allDiff) nxt[b] = ~deb[b];
            end
        end
        return nxt;
    endfunction

    task automatic checkAll();
        checkOutput("deb_db4",   outVec4,         modelDeb4);
        checkOutput("cfg_db4",   {9'd0, cfg4},    {9'd0, expCfg4});
        checkOutput("start_db4", {9'd0, spulse4}, {9'd0, expStart4});
        checkOutput("deb_db1",   outVec1,         modelDeb1);
        checkOutput("cfg_db1",   {9'd0, cfg1},    {9'd0, expCfg1});
        checkOutput("start_db1", {9'd0, spulse1}, {9'd0, expStart1});
    endtask

    task automatic applyStimulus(input logic [9:0] value, input int cycles);
        logic [9:0] seen, n4, n1;
        for (int c = 0; c < cycles; c++) begin
            raw = value;
            @(posedge clk);
            rawHist.push_back(value);
            seen = (rawHist.size() >= 3) ? rawHist[rawHist.size() - 3] : 10'd0;
            seenHist.push_back(seen);
            n4 = modelStep(4, modelDeb4);
            n1 = modelStep(1, modelDeb1);
            expCfg4   = (n4[8:0] != modelDeb4[8:0]);
            expStart4 = n4[9] & ~modelDeb4[9];
            expCfg1   = (n1[8:0] != modelDeb1[8:0]);
            expStart1 = n1[9] & ~modelDeb1[9];
            modelDeb4 = n4;
            modelDeb1 = n1;
            if (rawHist.size() > 4) void'(rawHist.pop_front());
            if (seenHist.size() > 8) void'(seenHist.pop_front());
            #1;
            checkAll();
        end
    endtask

    task automatic clearModel();
        rawHist.delete();
        seenHist.delete();
        modelDeb4 = '0;
        modelDeb1 = '0;
        expCfg4   = 1'b0;
        expStart4 = 1'b0;
        expCfg1   = 1'b0;
        expStart1 = 1'b0;
    endtask

    task automatic applyReset(input int held);
        #1;
        rst = 1'b1;
        clearModel();
        #1;
        checkAll();
        repeat (held) @(posedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll();
    endtask

    initial begin
        logic [9:0] cur;
        rst = 1'b1;
        raw = '0;
        clearModel();
        #2;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        // Single red bit: visible after the sixth edge with one cfg pulse.
        applyStimulus(10'h001, 5);
        checkOutput("red_early", {8'd0, red4}, 10'd0);
        applyStimulus(10'h001, 1);
        checkOutput("red_sixth", {8'd0, red4}, 10'd1);
        checkOutput("red_cfg",   {9'd0, cfg4}, 10'd1);
        applyStimulus(10'h001, 1);
        checkOutput("red_cfg_once", {9'd0, cfg4}, 10'd0);
        applyStimulus(10'h000, 8);

        // Short gtype glitch is rejected.
        applyStimulus(10'h100, 3);
        applyStimulus(10'h000, 8);
        checkOutput("gtype_glitch", {9'd0, gtype4}, 10'd0);

        // Several configuration bits change together.
        applyStimulus(10'h0F3, 5);
        checkOutput("multi_early", outVec4, 10'h000);
        applyStimulus(10'h0F3, 1);
        checkOutput("multi_deb", outVec4, 10'h0F3);
        checkOutput("multi_cfg", {9'd0, cfg4}, 10'd1);
        applyStimulus(10'h0F3, 1);
        checkOutput("multi_cfg_once", {9'd0, cfg4}, 10'd0);
        applyStimulus(10'h000, 8);

        // Start switch press and release.
        applyStimulus(10'h200, 5);
        checkOutput("start_early", {9'd0, start4}, 10'd0);
        applyStimulus(10'h200, 1);
        checkOutput("start_level", {9'd0, start4},  10'd1);
        checkOutput("start_pulse", {9'd0, spulse4}, 10'd1);
        checkOutput("start_nocfg", {9'd0, cfg4},    10'd0);
        applyStimulus(10'h200, 14);
        applyStimulus(10'h000, 6);
        checkOutput("start_release", {9'd0, start4},  10'd0);
        checkOutput("release_pulse", {9'd0, spulse4}, 10'd0);
        checkOutput("release_nocfg", {9'd0, cfg4},    10'd0);

        // Reset in the middle of a green count.
        applyStimulus(10'h00C, 3);
        applyReset(2);
        applyStimulus(10'h00C, 5);
        checkOutput("green_early", {8'd0, green4}, 10'd0);
        applyStimulus(10'h00C, 1);
        checkOutput("green_after_rst", {8'd0, green4}, 10'd3);
        checkOutput("green_cfg", {9'd0, cfg4}, 10'd1);

        // Single-cycle debounce build: third edge.
        raw = 10'h000;
        applyReset(1);
        applyStimulus(10'h0C0, 2);
        checkOutput("tran_db1_early", {8'd0, tran1}, 10'd0);
        applyStimulus(10'h0C0, 1);
        checkOutput("tran_db1", {8'd0, tran1}, 10'd3);
        applyStimulus(10'h0C0, 4);

        // Random bouncing segments with occasional resets.
        cur = 10'h0C0;
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 3) == 0)
                cur = 10'($urandom);
            else
                cur = cur ^ (10'd1 << $urandom_range(0, 9));
            applyStimulus(cur, $urandom_range(1, 7));
            if ($urandom_range(0, 49) == 0) applyReset($urandom_range(1, 3));
        end
        applyStimulus(cur, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
